rc5_key_expand: RTL and testbench

//  - RC5 key schedule: expands a B-byte secret key into the T=2*(R+1) word table S[] and serves it to the downstream cipher.
//  - Sits directly upstream of the encryption datapath; the cipher's oS_address1/2 drive iS_address1/2 here, and oS_sub_i1/2 feed its iS_sub_i1/2.
//  - Holds S[] and L[] in internal register arrays; table valid only while oDone=1.

---
 rtl/rc5_key_expand_if.sv | 31 +++
 rtl/rc5_key_expand.sv | 183 ++++++++++++++++++
 tb/tb_rc5_key_expand.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rc5_key_expand_if.sv
// RC5 key schedule bus: start/key from the host side, the two S[] read
// ports from the cipher side, and the busy/done status back to both.
interface rc5_key_expand_if #(
  parameter int W = 32,
  parameter int R = 12,
  parameter int B = 16
);
  localparam int T        = 2 * (R + 1);
  localparam int T_LENGTH = $clog2(T);

  logic                iStart;
  logic [8*B-1:0]      iKey;
  logic [T_LENGTH-1:0] iS_address1;
  logic [T_LENGTH-1:0] iS_address2;
  logic [W-1:0]        oS_sub_i1;
  logic [W-1:0]        oS_sub_i2;
  logic                oBusy;
  logic                oDone;

  // Host / cipher side.
  modport master (
    output iStart, iKey, iS_address1, iS_address2,
    input  oS_sub_i1, oS_sub_i2, oBusy, oDone
  );

  // Key-expansion side.
  modport slave (
    input  iStart, iKey, iS_address1, iS_address2,
    output oS_sub_i1, oS_sub_i2, oBusy, oDone
  );
endinterface

// File: rtl/rc5_key_expand.sv
// RC5 key schedule. Expands a B-byte key into the T = 2*(R+1) word table S[]
// and serves it through two registered read ports to the cipher datapath.
// Sequence: IDLE -> LOAD_L -> INIT_S (T cycles) -> MIX_A/MIX_B (N pairs) -> DONE.
// Dropping iStart or raising rst aborts to IDLE at the next posedge.
// Optional build macro RC5_KEYEXP_ZEROIZE_EN: clear S[]/L[] on abort and
// force the read ports to 0 whenever oDone is low.
module rc5_key_expand #(
  parameter int W = 32,
  parameter int R = 12,
  parameter int B = 16
) (
  input  logic                clk,
  input  logic                rst,
  rc5_key_expand_if.slave     bus
);

  localparam int T        = 2 * (R + 1);
  localparam int T_LENGTH = $clog2(T);
  localparam int U        = W / 8;
  localparam int C_RAW    = (B + U - 1) / U;
  localparam int C        = (C_RAW < 1) ? 1 : C_RAW;
  localparam int N        = 3 * ((T > C) ? T : C);
  localparam int RW       = $clog2(W);
  localparam int JW       = (C > 1) ? $clog2(C) : 1;
  localparam int KW       = $clog2(N);

  localparam logic [63:0] P64 = (W == 16) ? 64'h0000_0000_0000_B7E1 :
                                (W == 32) ? 64'h0000_0000_B7E1_5163 :
                                            64'hB7E1_5162_8AED_2A6B;
  localparam logic [63:0] Q64 = (W == 16) ? 64'h0000_0000_0000_9E37 :
                                (W == 32) ? 64'h0000_0000_9E37_79B9 :
                                            64'h9E37_79B9_7F4A_7C15;
  localparam logic [W-1:0] P = P64[W-1:0];
  localparam logic [W-1:0] Q = Q64[W-1:0];

  localparam logic [T_LENGTH-1:0] T_LAST = T_LENGTH'(T - 1);
  localparam logic [JW-1:0]       C_LAST = JW'(C - 1);
  localparam logic [KW-1:0]       N_LAST = KW'(N - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_L,
    INIT_S,
    MIX_A,
    MIX_B,
    DONE
  } state_t;

  state_t              state;
  state_t              next_state;

  logic [W-1:0]        s_mem [T];
  logic [W-1:0]        l_mem [C];

  logic [T_LENGTH-1:0] i;
  logic [T_LENGTH-1:0] i_prev;
  logic [JW-1:0]       j;
  logic [KW-1:0]       k;
  logic [W-1:0]        a;
  logic [W-1:0]        bv;
  logic                busy;
  logic                done;
  logic [W-1:0]        rd1;
  logic [W-1:0]        rd2;

  logic                abort;
  logic [W-1:0]        init_val;
  logic [W-1:0]        mix_a_val;
  logic [W-1:0]        ab_sum;
  logic [W-1:0]        mix_b_val;
  logic [8*C*U-1:0]    key_pad;

  // Left rotate; only the low log2(W) bits of the amount matter, so 0 passes through.
  function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [RW-1:0] n);
    logic [2*W-1:0] d;
    d = {x, x} << n;
    return d[2*W-1:W];
  endfunction

  assign abort     = rst || !bus.iStart;
  assign i_prev    = i - 1'b1;
  assign init_val  = (i == '0) ? P : s_mem[i_prev] + Q;
  assign mix_a_val = rotl(s_mem[i] + a + bv, RW'(3));
  // MIX_B runs the cycle after MIX_A, so `a` already holds the freshly mixed A.
  assign ab_sum    = a + bv;
  assign mix_b_val = rotl(l_mem[j] + ab_sum, ab_sum[RW-1:0]);
  // Zero-extend so the missing high bytes of the last L word load as 0.
  assign key_pad   = (8*C*U)'(bus.iKey);

  // Next-state logic; iStart low forces IDLE from any state.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    next_state = state;
    if (!bus.iStart) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    next_state = LOAD_L;
        LOAD_L:  next_state = INIT_S;
        INIT_S:  if (i == T_LAST) next_state = MIX_A;
        MIX_A:   next_state = MIX_B;
        MIX_B:   next_state = (k == N_LAST) ? DONE : MIX_A;
        DONE:    next_state = DONE;
        default: next_state = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is written with <= only, so every register sees pre-edge values.
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Loop counters, A/B accumulators and the registered status flags.
  always_ff @(posedge clk) begin
    if (abort) begin
      i    <= '0;
      j    <= '0;
      k    <= '0;
      a    <= '0;
      bv   <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state == LOAD_L) || (state == INIT_S) || (state == MIX_A) || (state == MIX_B);
      done <= (state == DONE);
      case (state)
        INIT_S: i <= (i == T_LAST) ? '0 : i + 1'b1;
        MIX_A:  a <= mix_a_val;
        MIX_B: begin
          bv <= mix_b_val;
          i  <= (i == T_LAST) ? '0 : i + 1'b1;
          j  <= (j == C_LAST) ? '0 : j + 1'b1;
          k  <= k + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // S[] and L[] storage; writes are suppressed in an abort cycle.
  always_ff @(posedge clk) begin
    // NOTE: the tables have no reset; they are fully rewritten before oDone can rise.
    if (abort) begin
`ifdef RC5_KEYEXP_ZEROIZE_EN
      for (int t = 0; t < T; t++) s_mem[t] <= '0;
      for (int c = 0; c < C; c++) l_mem[c] <= '0;
`endif
    end else begin
      case (state)
        LOAD_L: for (int w = 0; w < C; w++) l_mem[w] <= key_pad[w*W +: W];
        INIT_S: s_mem[i] <= init_val;
        MIX_A:  s_mem[i] <= mix_a_val;
        MIX_B:  l_mem[j] <= mix_b_val;
        default: ;
      endcase
    end
  end

  // Registered read ports; live in every state and return the pre-write value.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd1 <= '0;
      rd2 <= '0;
    end else begin
      rd1 <= (bus.iS_address1 <= T_LAST) ? s_mem[bus.iS_address1] : '0;
      rd2 <= (bus.iS_address2 <= T_LAST) ? s_mem[bus.iS_address2] : '0;
    end
  end

`ifdef RC5_KEYEXP_ZEROIZE_EN
  assign bus.oS_sub_i1 = done ? rd1 : '0;
  assign bus.oS_sub_i2 = done ? rd2 : '0;
`else
  assign bus.oS_sub_i1 = rd1;
  assign bus.oS_sub_i2 = rd2;
`endif
  assign bus.oBusy = busy;
  assign bus.oDone = done;

endmodule

// File: tb/tb_rc5_key_expand.sv
// Bench for rc5_key_expand (W=32, R=12, B=16). Reads are queued with their
// expected values; a monitor pops and compares on the cycle the data appears.
module tb_rc5_key_expand;

  localparam int W = 32;
  localparam int R = 12;
  localparam int B = 16;
  localparam int T = 26;
  localparam logic [31:0] P32    = 32'hB7E15163;
  localparam logic [31:0] S1_EXP = 32'h5618CB1C;   // P + Q mod 2^32
  localparam logic [31:0] CT_A   = 32'hEEDBA521;
  localparam logic [31:0] CT_B   = 32'h6D8F4B15;
`ifdef RC5_KEYEXP_ZEROIZE_EN
  localparam bit ZEROIZE = 1'b1;
`else
  localparam bit ZEROIZE = 1'b0;
`endif

  typedef struct {
    string       name;
    int          a1;
    int          a2;
    logic [31:0] e1;
    logic [31:0] e2;
  } rd_exp_t;

  logic        clk = 1'b0;
  logic        rst;
  bit          rd_req;
  rd_exp_t     rd_q[$];
  int          checks;
  int          errors;
  int          e;
  logic [31:0] gold [T];
  logic [31:0] cap  [T];
  logic [127:0] key3;

  always #5 clk = ~clk;

  rc5_key_expand_if #(.W(W), .R(R), .B(B)) bus ();

  rc5_key_expand #(.W(W), .R(R), .B(B)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rotl32(input logic [31:0] x, input int n);
    int m;
    m = n & 31;
    return (m == 0) ? x : ((x << m) | (x >> (32 - m)));
  endfunction

  // Reference RC5-32/12/16 key schedule, written the way the C reference reads.
  task automatic compute_gold(input logic [127:0] key);
    logic [31:0] l [4];
    logic [31:0] ga, gb;
    int ii, jj;
    for (int w = 0; w < 4; w++) l[w] = '0;
    for (int b = 15; b >= 0; b--) l[b/4] = (l[b/4] << 8) + {24'h0, key[8*b +: 8]};
    gold[0] = P32;
    for (int t = 1; t < T; t++) gold[t] = gold[t-1] + 32'h9E3779B9;
    ga = '0; gb = '0; ii = 0; jj = 0;
    for (int kk = 0; kk < 78; kk++) begin
      ga = rotl32(gold[ii] + ga + gb, 3);
      gold[ii] = ga;
      gb = rotl32(l[jj] + ga + gb, int'((ga + gb) & 32'd31));
      l[jj] = gb;
      ii = (ii + 1) % T;
      jj = (jj + 1) % 4;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input int target);
    while (e < target) begin
      step();
      e++;
    end
  endtask

  task automatic wait_done();
    while (bus.oDone !== 1'b1 && e < 400) begin
      step();
      e++;
    end
  endtask

  task automatic do_read(input string name, input int a1, input int a2,
                         input logic [31:0] e1, input logic [31:0] e2);
    rd_exp_t x;
    x.name = name; x.a1 = a1; x.a2 = a2; x.e1 = e1; x.e2 = e2;
    rd_q.push_back(x);
    bus.iS_address1 = 5'(a1);
    bus.iS_address2 = 5'(a2);
    rd_req = 1'b1;
    step();
    e++;
    rd_req = 1'b0;
  endtask

  task automatic read_all(input string name, input bit expect_zero);
    for (int a = 0; a < T; a++)
      do_read(name, a, T - 1 - a, expect_zero ? 32'h0 : gold[a],
              expect_zero ? 32'h0 : gold[T-1-a]);
  endtask

  // Monitor: compare read data one cycle after each request.
  always @(posedge clk) begin : monitor
    rd_exp_t x;
    if (rd_req) begin
      #1;
      if (rd_q.size() == 0) begin
        check("scoreboard_underflow", 64'(rd_q.size()), 64'd1);
      end else begin
        x = rd_q.pop_front();
        check($sformatf("%s_p1_a%0d", x.name, x.a1), bus.oS_sub_i1, x.e1);
        check($sformatf("%s_p2_a%0d", x.name, x.a2), bus.oS_sub_i2, x.e2);
        if (x.a1 < T) cap[x.a1] = bus.oS_sub_i1;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin : stimulus
    logic [31:0] ca, cb;
    checks = 0; errors = 0; e = 0; rd_req = 1'b0;
    rst = 1'b1;
    bus.iStart = 1'b0;
    bus.iKey = '0;
    bus.iS_address1 = '0;
    bus.iS_address2 = '0;
    key3 = {8'hFF, 112'h0, 8'h01};

    // Reset state.
    repeat (3) step();
    check("rst_done", bus.oDone, 0);
    check("rst_busy", bus.oBusy, 0);
    check("rst_rd1", bus.oS_sub_i1, 0);
    check("rst_rd2", bus.oS_sub_i2, 0);
    rst = 1'b0;
    step();

    // T1: zero key, exact latency and INIT_S peek.
    bus.iKey = '0;
    bus.iStart = 1'b1;
    step(); e = 0;
    check("t1_busy_e0", bus.oBusy, 0);
    step(); e = 1;
    check("t1_busy_e1", bus.oBusy, 1);
    run_to(27);
    do_read("t1_peek", 0, 1, ZEROIZE ? 32'h0 : P32, ZEROIZE ? 32'h0 : S1_EXP);
    run_to(183);
    check("t1_busy_e183", bus.oBusy, 1);
    check("t1_done_e183", bus.oDone, 0);
    wait_done();
    check("t1_done_edge", 64'(e), 64'd184);
    check("t1_busy_at_done", bus.oBusy, 0);

    // T2: full table against the model, then encrypt 0/0 with what was read.
    compute_gold('0);
    read_all("t2_rd", 1'b0);
    step();
    ca = cap[0];
    cb = cap[1];
    for (int r = 1; r <= R; r++) begin
      ca = rotl32(ca ^ cb, int'(cb[4:0])) + cap[2*r];
      cb = rotl32(cb ^ ca, int'(ca[4:0])) + cap[2*r+1];
    end
    check("t2_ct_a", ca, CT_A);
    check("t2_ct_b", cb, CT_B);

    // iStart-only abort after DONE: ports stay live (or read 0 when zeroizing).
    bus.iStart = 1'b0;
    step();
    check("t3_abort_done", bus.oDone, 0);
    read_all("t3_abort_rd", ZEROIZE);

    // T3: non-trivial key, key bus scrambled mid-MIX.
    bus.iKey = key3;
    bus.iStart = 1'b1;
    step(); e = 0;
    run_to(100);
    bus.iKey = 128'h0123456789ABCDEF_FEDCBA9876543210;
    wait_done();
    check("t3_done_edge", 64'(e), 64'd184);
    compute_gold(key3);
    read_all("t3_rd", 1'b0);

    // T4: abort at edge 60, restart at edge 62, full rerun.
    bus.iKey = key3;
    bus.iStart = 1'b0;
    step();
    bus.iStart = 1'b1;
    step(); e = 0;
    run_to(59);
    bus.iStart = 1'b0;
    step(); e = 60;
    check("t4_abort_busy", bus.oBusy, 0);
    check("t4_abort_done", bus.oDone, 0);
    step(); e = 61;
    bus.iStart = 1'b1;
    step(); e = 0;
    wait_done();
    check("t4_done_edge", 64'(e), 64'd184);
    read_all("t4_rd", 1'b0);

    // T5: out-of-range address and both ports on one word.
    do_read("t5_a25_a26", 25, 26, gold[25], 32'h0);
    do_read("t5_same7", 7, 7, gold[7], gold[7]);

    // rst pulse mid-run at edge 100.
    bus.iStart = 1'b0;
    step();
    bus.iStart = 1'b1;
    step(); e = 0;
    run_to(99);
    rst = 1'b1;
    step(); e = 100;
    check("rst_pulse_busy", bus.oBusy, 0);
    check("rst_pulse_done", bus.oDone, 0);
    check("rst_pulse_rd1", bus.oS_sub_i1, 0);
    check("rst_pulse_rd2", bus.oS_sub_i2, 0);
    rst = 1'b0;
    bus.iStart = 1'b0;
    repeat (2) step();
    check("scoreboard_drained", 64'(rd_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
